// File: rtl/hrange_arb_pkg.sv
// Shared types and helpers for the hrange arbiter: FSM state encoding and
// index-width derivation.
package hrange_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // A single caller still needs a 1-bit index register.
  function automatic int unsigned idx_w(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_pick
  import hrange_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/hrange_arbiter.sv
// Shares one hrange generator between NUM_REQ callers: latches the granted call,
// launches the generator and routes its output stream back to that caller.
module hrange_arbiter
  import hrange_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic [NUM_REQ-1:0]       req_start,
  input  logic [NUM_REQ*WIDTH-1:0] req_base,
  input  logic [NUM_REQ*WIDTH-1:0] req_limit,
  input  logic [NUM_REQ*WIDTH-1:0] req_step,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [WIDTH-1:0]         out_0,
  output logic                     callee_start,
  output logic [WIDTH-1:0]         callee_base,
  output logic [WIDTH-1:0]         callee_limit,
  output logic [WIDTH-1:0]         callee_step,
  input  logic [WIDTH-1:0]         callee_0,
  input  logic                     callee_valid,
  input  logic                     callee_ready
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [WIDTH-1:0]   base_q, base_d, limit_q, limit_d, step_q, step_d;
  logic               start_q, start_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] g_onehot;

  logic [WIDTH-1:0] base_arr  [NUM_REQ];
  logic [WIDTH-1:0] limit_arr [NUM_REQ];
  logic [WIDTH-1:0] step_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign base_arr[i]  = req_base[i*WIDTH +: WIDTH];
    assign limit_arr[i] = req_limit[i*WIDTH +: WIDTH];
    assign step_arr[i]  = req_step[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req(req_start),
    .ptr(rr_ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign g_onehot = NUM_REQ'(1) << g_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    base_d   = base_q;
    limit_d  = limit_q;
    step_d   = step_q;
    start_d  = 1'b0;
    ack_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any && callee_ready) begin
          g_d     = pick_idx;
          base_d  = base_arr[pick_idx];
          limit_d = limit_arr[pick_idx];
          step_d  = step_arr[pick_idx];
          start_d = 1'b1;
          ack_d   = NUM_REQ'(1) << pick_idx;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (callee_ready) begin
          rr_ptr_d = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      base_q   <= '0;
      limit_q  <= '0;
      step_q   <= '0;
      start_q  <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      step_q   <= step_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
    end
  end

  assign callee_start = start_q;
  assign callee_base  = base_q;
  assign callee_limit = limit_q;
  assign callee_step  = step_q;
  assign req_ack      = ack_q;
  assign out_0        = callee_0;

  // Gated by reset so an aborted call never reports a word or completion.
  assign req_valid = (state_q == BUSY && callee_valid && !_reset) ? g_onehot : '0;
  assign req_done  = (state_q == BUSY && callee_ready && !_reset) ? g_onehot : '0;

endmodule

// File: tb/tb_hrange_arbiter.sv
// Directed bench for hrange_arbiter with a behavioural hrange generator and an
// in-order event scoreboard (ack / valid word / done per caller).
module tb_hrange_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;

  typedef enum logic [1:0] {EV_NONE, EV_ACK, EV_VALID, EV_DONE} ev_kind_e;
  typedef struct packed {
    ev_kind_e     kind;
    logic [3:0]   caller;
    logic [W-1:0] data;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_start;
  logic [NREQ*W-1:0] req_base, req_limit, req_step;
  logic [NREQ-1:0]   req_ack, req_valid, req_done;
  logic [W-1:0]      out_0, callee_base, callee_limit, callee_step, callee_0;
  logic              callee_start, callee_valid, callee_ready;

  always #5 clk = ~clk;

  hrange_arbiter #(
    .NUM_REQ(NREQ),
    .WIDTH  (W)
  ) dut (
    ._clock      (clk),
    ._reset      (rst),
    .req_start   (req_start),
    .req_base    (req_base),
    .req_limit   (req_limit),
    .req_step    (req_step),
    .req_ack     (req_ack),
    .req_valid   (req_valid),
    .req_done    (req_done),
    .out_0       (out_0),
    .callee_start(callee_start),
    .callee_base (callee_base),
    .callee_limit(callee_limit),
    .callee_step (callee_step),
    .callee_0    (callee_0),
    .callee_valid(callee_valid),
    .callee_ready(callee_ready)
  );

  // Generator model: emits base, base+step, ... while < limit; ready rises with the last word.
  logic                gen_busy, stray;
  logic signed [W-1:0] gen_cur, gen_lim, gen_step;

  always @(posedge clk) begin
    if (rst) begin
      gen_busy <= 1'b0;
      gen_cur  <= '0;
      gen_lim  <= '0;
      gen_step <= '0;
    end else if (callee_start) begin
      gen_busy <= 1'b1;
      gen_cur  <= callee_base;
      gen_lim  <= callee_limit;
      gen_step <= callee_step;
    end else if (gen_busy) begin
      gen_cur <= gen_cur + gen_step;
      if (callee_ready) gen_busy <= 1'b0;
    end
  end

  assign callee_ready = !gen_busy || (gen_cur + gen_step >= gen_lim);
  assign callee_valid = (gen_busy && gen_cur < gen_lim) || stray;
  assign callee_0     = gen_cur;

  ev_t sb[$];
  int  ack_cyc[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  rereq[NREQ];

  function automatic ev_t mk_ev(ev_kind_e k, int c, logic [W-1:0] d);
    ev_t e;
    e.kind   = k;
    e.caller = 4'(c);
    e.data   = d;
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(ev_t obs);
    ev_t exp;
    if (sb.size() != 0) exp = sb.pop_front();
    else exp = mk_ev(EV_NONE, 0, '0);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL event: observed kind %0d caller %0d data %0d, expected kind %0d caller %0d data %0d",
             obs.kind, obs.caller, $signed(obs.data), exp.kind, exp.caller, $signed(exp.data));
    end
  endtask

  task automatic monitor();
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i] === 1'b1)   check_ev(mk_ev(EV_ACK, i, '0));
      if (req_valid[i] === 1'b1) check_ev(mk_ev(EV_VALID, i, out_0));
      if (req_done[i] === 1'b1)  check_ev(mk_ev(EV_DONE, i, '0));
    end
  endtask

  // Sample at the falling edge, then step to 1 time unit past the next rising edge
  // and play the callers: drop on ack, optionally re-request on done.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i] === 1'b1) begin
        req_start[i] = 1'b0;
        ack_cyc.push_back(cyc);
      end
      if (req_done[i] === 1'b1 && rereq[i] > 0) begin
        req_start[i] = 1'b1;
        rereq[i]--;
      end
    end
  endtask

  task automatic set_args(int c, int b, int l, int s);
    req_base[c*W +: W]  = W'(b);
    req_limit[c*W +: W] = W'(l);
    req_step[c*W +: W]  = W'(s);
  endtask

  task automatic expect_call(int c, int b, int l, int s);
    sb.push_back(mk_ev(EV_ACK, c, '0));
    for (int v = b; v < l; v += s) sb.push_back(mk_ev(EV_VALID, c, W'(v)));
    sb.push_back(mk_ev(EV_DONE, c, '0));
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_ack"}, 64'(req_ack), 64'd0);
    check({tag, "_valid"}, 64'(req_valid), 64'd0);
    check({tag, "_done"}, 64'(req_done), 64'd0);
    check({tag, "_start"}, 64'(callee_start), 64'd0);
    check({tag, "_base"}, 64'(callee_base), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_start = '0;
    req_base  = '0;
    req_limit = '0;
    req_step  = '0;
    stray     = 1'b0;
    for (int i = 0; i < NREQ; i++) rereq[i] = 0;

    repeat (3) tick();
    check_quiet("reset");
    check("reset_limit", 64'(callee_limit), 64'd0);
    check("reset_step", 64'(callee_step), 64'd0);
    rst = 1'b0;
    tick();

    // All callers at once from rr_ptr 0: grants 0,1,2,3, 3 words each.
    for (int i = 0; i < NREQ; i++) begin
      set_args(i, i * 100, i * 100 + 3, 1);
      expect_call(i, i * 100, i * 100 + 3, 1);
    end
    ack_cyc.delete();
    req_start = '1;
    drain("all_four_drain");
    check("all_four_acks", 64'(ack_cyc.size()), 64'd4);
    for (int k = 0; k + 1 < ack_cyc.size(); k++)
      check("launch_spacing", 64'(ack_cyc[k+1] - ack_cyc[k]), 64'd5);

    // Single caller 0, ack latency, and caller 3 withdrawing while busy.
    set_args(0, 0, 10, 2);
    expect_call(0, 0, 10, 2);
    req_start[0] = 1'b1;
    tick();
    check("ack_latency", 64'(req_ack), 64'b0001);
    check("launch_start", 64'(callee_start), 64'd1);
    check("launch_base", 64'(callee_base), 64'd0);
    check("launch_limit", 64'(callee_limit), 64'd10);
    check("launch_step", 64'(callee_step), 64'd2);
    tick();
    check("start_one_cycle", 64'(callee_start), 64'd0);
    check("ack_one_cycle", 64'(req_ack), 64'd0);
    tick();
    req_start[3] = 1'b1;
    tick();
    req_start[3] = 1'b0;
    drain("single0_drain");

    // Empty range on caller 2, then stray valid while idle.
    set_args(2, 5, 5, 1);
    expect_call(2, 5, 5, 1);
    req_start[2] = 1'b1;
    drain("empty_drain");
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    tick();

    // Fairness from rr_ptr 3: callers 1 and 2 keep re-requesting.
    set_args(1, 10, 12, 1);
    set_args(2, 20, 21, 1);
    expect_call(1, 10, 12, 1);
    expect_call(2, 20, 21, 1);
    expect_call(1, 10, 12, 1);
    expect_call(2, 20, 21, 1);
    rereq[1] = 1;
    rereq[2] = 1;
    req_start[1] = 1'b1;
    req_start[2] = 1'b1;
    drain("fairness_drain");

    // Reset in the middle of a long call: four words seen, then abort.
    set_args(0, 0, 100, 1);
    sb.push_back(mk_ev(EV_ACK, 0, '0));
    for (int v = 0; v < 4; v++) sb.push_back(mk_ev(EV_VALID, 0, W'(v)));
    req_start[0] = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_quiet("midreset");
    rst = 1'b0;
    tick();
    check("midreset_no_done", 64'(sb.size()), 64'd0);

    // After reset rr_ptr is 0, so caller 2 goes before caller 3.
    set_args(2, 7, 8, 1);
    set_args(3, -3, -1, 1);
    expect_call(2, 7, 8, 1);
    expect_call(3, -3, -1, 1);
    req_start[2] = 1'b1;
    req_start[3] = 1'b1;
    drain("post_reset_drain");
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
